// File: rtl/conv_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_tile_sched
// Purpose  : Loop-nest scheduler for the CONV layer engine. It walks filter
//            groups, output rows and output columns, and issues one job per
//            output pixel to the systolic-array controller over a valid/ready
//            handshake. Each job carries precomputed BRAM base addresses for
//            the input window, the weight group and the output pixel, plus a
//            channel mask.
// Ports    : clk, rst (async, active low), start (pulse, IDLE only)
//            do_ch, di, dc, dkr, dkc, dr_out, dc_out  layer dimensions
//              (the output-channel count is do_ch because "do" is a reserved
//              word)
//            step (stride 1..7), inaddr, waddr, outaddr  layer base addresses
//            job_valid/job_ready  job handshake
//            job_in_addr, job_w_addr, job_out_addr, job_ch_mask, job_last
//            busy (high outside IDLE), done (one-cycle completion pulse)
//            stall_cnt, job_cnt  32-bit counters, only when SCHED_PERF_EN
//            is defined
// Revision : 1.0 - initial release
// ============================================================================
module conv_tile_sched #(
    parameter int COLS       = 4,
    parameter int MEMADDRBIT = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEMADDRBIT-1:0] do_ch,
    input  logic [MEMADDRBIT-1:0] di,
    input  logic [MEMADDRBIT-1:0] dc,
    input  logic [MEMADDRBIT-1:0] dkr,
    input  logic [MEMADDRBIT-1:0] dkc,
    input  logic [MEMADDRBIT-1:0] dr_out,
    input  logic [MEMADDRBIT-1:0] dc_out,
    input  logic [2:0]            step,
    input  logic [MEMADDRBIT-1:0] inaddr,
    input  logic [MEMADDRBIT-1:0] waddr,
    input  logic [MEMADDRBIT-1:0] outaddr,
    output logic                  job_valid,
    input  logic                  job_ready,
    output logic [MEMADDRBIT-1:0] job_in_addr,
    output logic [MEMADDRBIT-1:0] job_w_addr,
    output logic [MEMADDRBIT-1:0] job_out_addr,
    output logic [COLS-1:0]       job_ch_mask,
    output logic                  job_last,
    output logic                  busy,
`ifdef SCHED_PERF_EN
    output logic [31:0]           stall_cnt,
    output logic [31:0]           job_cnt,
`endif
    output logic                  done
);

    localparam int                    c_log2_cols = $clog2(COLS);
    localparam logic [MEMADDRBIT-1:0] c_one       = MEMADDRBIT'(1);
    localparam logic [MEMADDRBIT-1:0] c_cols      = MEMADDRBIT'(COLS);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_precalc = 2'd1;
    localparam logic [1:0] c_st_issue   = 2'd2;
    localparam logic [1:0] c_st_finish  = 2'd3;

    // Bit i is set when filter i of the group exists, i.e. remaining > i.
    function automatic logic [COLS-1:0] mask_of(input logic [MEMADDRBIT-1:0] rem);
        logic [COLS-1:0] m;
        m = '0;
        for (int i = 0; i < COLS; i++) begin
            m[i] = (rem > MEMADDRBIT'(i));
        end
        return m;
    endfunction

    logic [1:0]            r_state;
    logic [MEMADDRBIT-1:0] r_do, r_di, r_dc, r_dkr, r_dkc, r_dr_out, r_dc_out;
    logic [2:0]            r_step;
    logic [MEMADDRBIT-1:0] r_inaddr, r_waddr, r_outaddr;
    logic [MEMADDRBIT-1:0] r_rowstride, r_wgrp, r_ogrp;
    logic [MEMADDRBIT-1:0] r_g_max, r_r_max, r_c_max;
    logic [MEMADDRBIT-1:0] r_g, r_r, r_c;
    logic [MEMADDRBIT-1:0] r_in_row, r_in_cur, r_w_cur, r_out_grp, r_out_cur;
    logic [MEMADDRBIT-1:0] r_rem;
    logic [COLS-1:0]       r_mask;
    logic                  r_job_valid, r_job_last, r_busy, r_done;

    logic [MEMADDRBIT-1:0] w_step_ext, w_rowstride, w_wgrp, w_ogrp, w_g_max;
    logic [MEMADDRBIT-1:0] w_c_inc, w_r_inc, w_g_inc;
    logic [MEMADDRBIT-1:0] w_in_row_next, w_out_grp_next, w_rem_next;
    logic                  w_zero_dim, w_accept, w_c_end, w_r_end, w_g_end;

    // Derived layer constants; products wrap modulo 2^MEMADDRBIT.
    assign w_step_ext  = {{(MEMADDRBIT-3){1'b0}}, r_step};
    assign w_rowstride = w_step_ext * r_dc;
    assign w_wgrp      = c_cols * r_di * r_dkr * r_dkc;
    assign w_ogrp      = c_cols * r_dr_out * r_dc_out;
    // ngroups-1 == (do-1)/COLS for do >= 1; COLS is a power of two.
    assign w_g_max     = (r_do - c_one) >> c_log2_cols;
    assign w_zero_dim  = (r_do == '0) || (r_dr_out == '0) || (r_dc_out == '0);

    assign w_accept       = r_job_valid && job_ready;
    assign w_c_end        = (r_c == r_c_max);
    assign w_r_end        = (r_r == r_r_max);
    assign w_g_end        = (r_g == r_g_max);
    assign w_c_inc        = r_c + c_one;
    assign w_r_inc        = r_r + c_one;
    assign w_g_inc        = r_g + c_one;
    assign w_in_row_next  = r_in_row + r_rowstride;
    assign w_out_grp_next = r_out_grp + r_ogrp;
    assign w_rem_next     = r_rem - c_cols;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_do        <= '0; r_di     <= '0; r_dc     <= '0; r_dkr <= '0;
            r_dkc       <= '0; r_dr_out <= '0; r_dc_out <= '0; r_step <= '0;
            r_inaddr    <= '0; r_waddr  <= '0; r_outaddr <= '0;
            r_rowstride <= '0; r_wgrp   <= '0; r_ogrp   <= '0;
            r_g_max     <= '0; r_r_max  <= '0; r_c_max  <= '0;
            r_g         <= '0; r_r      <= '0; r_c      <= '0;
            r_in_row    <= '0; r_in_cur <= '0; r_w_cur  <= '0;
            r_out_grp   <= '0; r_out_cur <= '0;
            r_rem       <= '0; r_mask   <= '0;
            r_job_valid <= 1'b0; r_job_last <= 1'b0;
            r_busy      <= 1'b0; r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_do     <= do_ch;  r_di     <= di;     r_dc  <= dc;
                        r_dkr    <= dkr;    r_dkc    <= dkc;    r_dr_out <= dr_out;
                        r_dc_out <= dc_out; r_step   <= step;
                        r_inaddr <= inaddr; r_waddr  <= waddr;  r_outaddr <= outaddr;
                        r_busy   <= 1'b1;
                        r_state  <= c_st_precalc;
                    end
                end
                c_st_precalc: begin
                    r_rowstride <= w_rowstride;
                    r_wgrp      <= w_wgrp;
                    r_ogrp      <= w_ogrp;
                    r_g_max     <= w_g_max;
                    r_r_max     <= r_dr_out - c_one;
                    r_c_max     <= r_dc_out - c_one;
                    r_g         <= '0; r_r <= '0; r_c <= '0;
                    r_in_row    <= r_inaddr; r_in_cur  <= r_inaddr;
                    r_w_cur     <= r_waddr;
                    r_out_grp   <= r_outaddr; r_out_cur <= r_outaddr;
                    r_rem       <= r_do;
                    r_mask      <= mask_of(r_do);
                    if (w_zero_dim) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_finish;
                    end else begin
                        r_job_valid <= 1'b1;
                        r_job_last  <= (w_g_max == '0) && (r_dr_out == c_one) &&
                                       (r_dc_out == c_one);
                        r_state     <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_accept) begin
                        if (!w_c_end) begin
                            r_c        <= w_c_inc;
                            r_in_cur   <= r_in_cur + w_step_ext;
                            r_out_cur  <= r_out_cur + c_one;
                            r_job_last <= (w_c_inc == r_c_max) && w_r_end && w_g_end;
                        end else if (!w_r_end) begin
                            r_c        <= '0;
                            r_r        <= w_r_inc;
                            r_in_row   <= w_in_row_next;
                            r_in_cur   <= w_in_row_next;
                            r_out_cur  <= r_out_cur + c_one;
                            r_job_last <= (r_c_max == '0) && (w_r_inc == r_r_max) && w_g_end;
                        end else if (!w_g_end) begin
                            r_c        <= '0;
                            r_r        <= '0;
                            r_g        <= w_g_inc;
                            r_in_row   <= r_inaddr;
                            r_in_cur   <= r_inaddr;
                            r_w_cur    <= r_w_cur + r_wgrp;
                            r_out_grp  <= w_out_grp_next;
                            r_out_cur  <= w_out_grp_next;
                            r_rem      <= w_rem_next;
                            r_mask     <= mask_of(w_rem_next);
                            r_job_last <= (r_c_max == '0) && (r_r_max == '0) &&
                                          (w_g_inc == r_g_max);
                        end else begin
                            r_job_valid <= 1'b0;
                            r_job_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= c_st_finish;
                        end
                    end
                end
                c_st_finish: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign job_valid    = r_job_valid;
    assign job_in_addr  = r_in_cur;
    assign job_w_addr   = r_w_cur;
    assign job_out_addr = r_out_cur;
    assign job_ch_mask  = r_mask;
    assign job_last     = r_job_last;
    assign busy         = r_busy;
    assign done         = r_done;

`ifdef SCHED_PERF_EN
    logic [31:0] r_stall_cnt, r_job_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_job_cnt   <= '0;
        end else if ((r_state == c_st_idle) && start) begin
            r_stall_cnt <= '0;
            r_job_cnt   <= '0;
        end else begin
            if (r_job_valid && !job_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_accept)                  r_job_cnt   <= r_job_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign job_cnt   = r_job_cnt;
`endif

endmodule
`default_nettype wire
